// File: rtl/instr_enc_pkg.sv
// Shared types and constants for instr_encoder: ALU codes, MIPS opcode/funct values,
// FSM states and the per-item encoding function.
package instr_enc_pkg;

    localparam int unsigned FIFO_W = 64;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic        ok;
        logic [31:0] instr;
    } enc_t;

    // Unsupported op/form combinations return ok=0 with an all-zero word.
    function automatic enc_t encode(input logic [3:0]  op,
                                    input logic        ssel,
                                    input logic [4:0]  rs1,
                                    input logic [4:0]  rs2,
                                    input logic [4:0]  rd,
                                    input logic [15:0] imm16);
        enc_t       r;
        logic [5:0] funct;
        r     = '0;
        funct = '0;
        if (ssel) begin
            r.ok = 1'b1;
            case (op)
                ALU_AND: funct = FN_AND;
                ALU_OR:  funct = FN_OR;
                ALU_ADD: funct = FN_ADD;
                ALU_SUB: funct = FN_SUB;
                ALU_SLT: funct = FN_SLT;
                ALU_NOR: funct = FN_NOR;
                default: r.ok = 1'b0;
            endcase
            if (r.ok) r.instr = {OPC_RTYPE, rs1, rs2, rd, 5'h00, funct};
        end else begin
            case (op)
                ALU_ADD: begin r.ok = 1'b1; r.instr = {OPC_ADDI, rs1, rd, imm16}; end
                ALU_SLT: begin r.ok = 1'b1; r.instr = {OPC_SLTI, rs1, rd, imm16}; end
                default: r.ok = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic imm_fits16(input logic [31:0] imm);
        return (&imm[31:15]) | ~(|imm[31:15]);
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Two-entry FIFO buffering encoded words between the input stream and the memory writer.
module instr_enc_fifo
    import instr_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FIFO_W-1:0] push_data,
    input  logic              pop,
    output logic [FIFO_W-1:0] pop_data,
    output logic              empty,
    output logic              full
);

    logic [FIFO_W-1:0] mem_q [2];
    logic [FIFO_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    assign empty    = (count_q == 2'd0);
    assign full     = (count_q == 2'd2);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // NOTE: every variable gets its default first so no path can infer a latch.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) rd_ptr_d = ~rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates its use and the top masks out_instr.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams ALU items into MIPS R/I-type words with byte addresses via a 2-entry FIFO.
// Optional legality checking (drop + sticky err) is enabled by INSTR_ENCODER_CHECK_EN.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        op,
    input  logic              ssel,
    input  logic [DWIDTH-1:0] imm,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rdst_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_instr,
    output logic [DWIDTH-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    enc_t              enc;
    logic              item_ok, accept, push, pop;
    logic              fifo_empty, fifo_full;
    logic [FIFO_W-1:0] fifo_rdata;
    logic              unused_bits;

    assign enc = encode(op, ssel, rs1_id, rs2_id, rdst_id, imm[15:0]);

`ifdef INSTR_ENCODER_CHECK_EN
    logic err_q, err_d;

    assign item_ok = enc.ok && (ssel || imm_fits16(imm));
    assign err_d   = err_q | (accept & ~item_ok);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign unused_bits = ^fifo_rdata[31:0];
`else
    // Illegal combinations still push, carrying the all-zero word from encode().
    assign item_ok     = 1'b1;
    assign err         = 1'b0;
    assign unused_bits = ^{fifo_rdata[31:0], imm[DWIDTH-1:16], enc.ok};
`endif

    assign in_ready  = (state_q == ST_STREAM) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && item_ok;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign busy      = (state_q != ST_IDLE);
    assign out_instr = out_valid ? fifo_rdata[FIFO_W-1:32] : '0;
    assign out_addr  = addr_q;

    instr_enc_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({enc.instr, 32'h0000_0000}),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done    = 1'b0;
        if (pop) addr_d = addr_q + DWIDTH'(4);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    addr_d  = base_addr;
                end
            end
            ST_STREAM: begin
                if (accept && in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized streams
// scored against a behavioural encoding/address model.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, ssel, out_ready;
    logic [31:0] base_addr, imm;
    logic [3:0]  op;
    logic [4:0]  rs1_id, rs2_id, rdst_id;
    logic        in_ready, out_valid, busy, done, err;
    logic [31:0] out_instr, out_addr;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb_q[$];
    logic [31:0] outs_addr[$];
    logic [31:0] outs_instr[$];
    logic [31:0] exp_addr;
    logic        err_exp;
    int          done_cnt;
    logic        accepted;
    logic        rand_ready;
    logic        hold_pend;
    logic [31:0] hold_instr, hold_addr;
    logic [3:0]  ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    instr_encoder #(.DWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .op        (op),
        .ssel      (ssel),
        .imm       (imm),
        .rs1_id    (rs1_id),
        .rs2_id    (rs2_id),
        .rdst_id   (rdst_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Reference encoding: returns {legal, word} from the ISA field layout by arithmetic.
    function automatic logic [32:0] ref_word(input logic [3:0] o, input logic s,
                                             input logic [4:0] a, input logic [4:0] b,
                                             input logic [4:0] d, input logic [31:0] im);
        longint w;
        int     f;
        int     opc;
        logic   legal;
        w = 0; f = -1; opc = -1; legal = 1'b0;
        if (s) begin
            case (o)
                4'd0:  f = 36;
                4'd1:  f = 37;
                4'd2:  f = 32;
                4'd6:  f = 34;
                4'd7:  f = 42;
                4'd12: f = 39;
                default: f = -1;
            endcase
            if (f >= 0) begin
                legal = 1'b1;
                w = longint'(a) * 2097152 + longint'(b) * 65536 + longint'(d) * 2048 + longint'(f);
            end
        end else begin
            if (o == 4'd2) opc = 8;
            else if (o == 4'd7) opc = 10;
            if (opc >= 0) begin
                legal = 1'b1;
                w = longint'(opc) * 67108864 + longint'(a) * 2097152 + longint'(d) * 65536
                    + longint'(im % 65536);
            end
        end
        return {legal, w[31:0]};
    endfunction

    function automatic bit fits16(input logic [31:0] im);
        int v;
        v = $signed(im);
        return (v >= -32768) && (v <= 32767);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: entered at a falling edge with inputs set, samples 1 ns later, ends at the next falling edge.
    task automatic cycle();
        logic [32:0] r;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = 1'b0;
        if (!rst) begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_instr", out_instr, hold_instr);
                check("hold_addr", out_addr, hold_addr);
            end
            hold_pend  = out_valid && !out_ready;
            hold_instr = out_instr;
            hold_addr  = out_addr;
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                r = ref_word(op, ssel, rs1_id, rs2_id, rdst_id, imm);
                if (CHECK_EN) begin
                    if (r[32] && (ssel || fits16(imm))) sb_q.push_back(r[31:0]);
                    else err_exp = 1'b1;
                end else begin
                    sb_q.push_back(r[32] ? r[31:0] : 32'h0);
                end
            end
            if (out_valid && out_ready) begin
                outs_addr.push_back(out_addr);
                outs_instr.push_back(out_instr);
                if (sb_q.size() == 0) begin
                    check("spurious_output", 32'(sb_q.size()), 32'd1);
                end else begin
                    check("out_instr", out_instr, sb_q.pop_front());
                    check("out_addr", out_addr, exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
            end
            if (done) done_cnt++;
        end else begin
            hold_pend = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic start_stream(input logic [31:0] base);
        exp_addr = base;
        done_cnt = 0;
        outs_addr.delete();
        outs_instr.delete();
        start     = 1'b1;
        base_addr = base;
        cycle();
        start     = 1'b0;
        base_addr = $urandom;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send(input logic [3:0] o, input logic s, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic [31:0] im,
                        input logic last);
        op = o; ssel = s; rs1_id = a; rs2_id = b; rdst_id = d; imm = im; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && done_cnt == 0; i++) cycle();
        cycle();
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(err_exp));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_out_addr"}, out_addr, 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'd0);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic        r_ssel;
        logic [31:0] r_imm;
        int          n_items;

        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        op = '0; ssel = 1'b0; imm = '0; rs1_id = '0; rs2_id = '0; rdst_id = '0;
        out_ready = 1'b0; rand_ready = 1'b0; err_exp = 1'b0; hold_pend = 1'b0;
        exp_addr = '0; done_cnt = 0;

        @(negedge clk);
        cycle();
        cycle();
        check_reset_state("reset");
        rst = 1'b0;
        cycle();

        // Single R-type ADD item
        out_ready = 1'b1;
        start_stream(32'h0000_0400);
        send(4'd2, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
        wait_done("radd");
        check("radd_count", 32'(outs_instr.size()), 32'd1);
        check("radd_instr", outs_instr[0], 32'h0022_1820);
        check("radd_addr", outs_addr[0], 32'h0000_0400);

        // addi with imm = -1
        start_stream(32'h0000_1000);
        send(4'd2, 1'b0, 5'd0, 5'd7, 5'd8, 32'hFFFF_FFFF, 1'b1);
        wait_done("addi");
        check("addi_instr", outs_instr[0], 32'h2008_FFFF);

        // Backpressure: third item must wait until the FIFO drains
        out_ready = 1'b0;
        start_stream(32'h0000_2000);
        send(4'd0, 1'b1, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
        send(4'd1, 1'b1, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0);
        op = 4'd7; ssel = 1'b0; rs1_id = 5'd9; rs2_id = 5'd0; rdst_id = 5'd10;
        imm = 32'd100; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            cycle();
        end
        out_ready = 1'b1;
        send(4'd7, 1'b0, 5'd9, 5'd0, 5'd10, 32'd100, 1'b1);
        wait_done("bp");
        check("bp_count", 32'(outs_addr.size()), 32'd3);
        check("bp_addr0", outs_addr[0], 32'h0000_2000);
        check("bp_addr1", outs_addr[1], 32'h0000_2004);
        check("bp_addr2", outs_addr[2], 32'h0000_2008);

        // Address wrap at the top of the space
        start_stream(32'hFFFF_FFFC);
        send(4'd6, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        send(4'd12, 1'b1, 5'd31, 5'd30, 5'd29, 32'd0, 1'b1);
        wait_done("wrap");
        check("wrap_addr0", outs_addr[0], 32'hFFFF_FFFC);
        check("wrap_addr1", outs_addr[1], 32'h0000_0000);

        // Immediate form with an op that has no immediate encoding
        start_stream(32'h0000_3000);
        send(4'd6, 1'b0, 5'd1, 5'd0, 5'd2, 32'd5, 1'b1);
        wait_done("illegal");
`ifdef INSTR_ENCODER_CHECK_EN
        check("illegal_dropped", 32'(outs_instr.size()), 32'd0);
        check("illegal_err", 32'(err), 32'd1);
`else
        check("illegal_zero_word", outs_instr[0], 32'h0000_0000);
        check("illegal_no_err", 32'(err), 32'd0);
`endif

        // Randomized streams with random backpressure, gaps and ignored start pulses
        rand_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            start_stream($urandom & 32'hFFFF_FFFC);
            n_items = $urandom_range(1, 8);
            for (int k = 0; k < n_items; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    start     = ($urandom_range(0, 1) == 1);
                    base_addr = $urandom;
                    cycle();
                    start = 1'b0;
                end
                r_ssel = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0) r_op = 4'($urandom_range(0, 15));
                else if (!r_ssel) r_op = ($urandom_range(0, 1) == 1) ? 4'd2 : 4'd7;
                else r_op = ops[$urandom_range(0, 5)];
                if ($urandom_range(0, 1) == 1) r_imm = 32'($urandom_range(0, 65535)) - 32'd32768;
                else r_imm = $urandom;
                send(r_op, r_ssel, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), r_imm, k == n_items - 1);
            end
            wait_done("rand");
        end
        rand_ready = 1'b0;

        // Reset in the middle of a stream with both FIFO entries occupied
        out_ready = 1'b0;
        start_stream(32'h0000_5000);
        send(4'd2, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        send(4'd1, 1'b1, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
        check("mid_full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_state("midrst");
        sb_q.delete();
        err_exp = 1'b0;
        out_ready = 1'b1;
        start_stream(32'h0000_6000);
        send(4'd0, 1'b1, 5'd10, 5'd11, 5'd12, 32'd0, 1'b1);
        wait_done("restart");
        check("restart_addr", outs_addr[0], 32'h0000_6000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DWIDTH, 32, instruction/data width; only 32 is supported.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  pulse; loads base_addr and begins a stream.
REQ-006 base_addr  in  32  byte address of the first emitted word.
REQ-007 in_valid/in_ready  in/out  1/1  input handshake; transfer when both are high.
REQ-008 in_last  in  1  marks the final item of the stream.
REQ-009 op  in  4  ALU code: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12.
REQ-010 ssel  in  1  1 = R-type (rs2 source); 0 = immediate form.
REQ-011 imm  in  32  immediate, sign-extended form.
REQ-012 rs1_id, rs2_id, rdst_id  in  5 each  register IDs.
REQ-013 out_valid/out_ready  out/in  1/1  output handshake to the instruction-memory writer.
REQ-014 out_instr  out  32  encoded MIPS word.
REQ-015 out_addr  out  32  byte address of out_instr.
REQ-016 busy  out  1  high while in STREAM or DRAIN.
REQ-017 done  out  1  one-cycle pulse when the stream completes.
REQ-018 err  out  1  sticky flag set on an illegal item.

Function
REQ-019 The FSM SHALL have three states: IDLE, STREAM and DRAIN.
  - IDLE -> STREAM on start.
  - STREAM -> DRAIN on acceptance of an item with in_last.
  - DRAIN -> IDLE when the FIFO is empty and no pop is in flight; done pulses in that cycle.
REQ-020 in_ready SHALL equal (state == STREAM) AND (FIFO not full); a start pulse outside IDLE SHALL be ignored.
REQ-021 R-type (ssel=1) encoding SHALL be {6'h00, rs1_id, rs2_id, rdst_id, 5'h0, funct}, with funct ADD=20h, SUB=22h, AND=24h, OR=25h, NOR=27h, SLT=2Ah.
REQ-022 I-type (ssel=0) encoding SHALL be {opcode, rs1_id, rdst_id, imm[15:0]}, with opcode ADD=08h (addi) and SLT=0Ah (slti).
REQ-023 An accepted item SHALL be encoded combinationally and pushed into a 2-entry FIFO in the same cycle, giving out_valid one cycle after acceptance when the FIFO was empty.
REQ-024 Push and pop in the same cycle SHALL be legal at count 1; a push SHALL never occur while the FIFO is full.
REQ-025 out_addr SHALL start at base_addr, add 4 on each output handshake, and wrap modulo 2^32.
REQ-026 out_instr and out_addr SHALL hold stable while out_valid is high and out_ready is low.

Reset
REQ-027 rst SHALL force, at the next edge and from any state (including mid-stream):
  - state = IDLE and FIFO empty;
  - out_valid, in_ready, busy, done and err = 0;
  - out_addr = 0 and out_instr = 0.

Configuration
REQ-028 With INSTR_ENCODER_CHECK_EN defined, the following items SHALL be illegal, dropped (never pushed) and SHALL set err:
  - an undefined op;
  - ssel=0 with op not ADD or SLT;
  - an imm not representable as a sign-extended 16-bit value.
  A dropped item carrying in_last SHALL still move the FSM to DRAIN.
REQ-029 Without INSTR_ENCODER_CHECK_EN, err SHALL be tied 0, imm SHALL be truncated to [15:0], and illegal combinations SHALL encode as 32'h00000000.

Structure
REQ-030 A shared package instr_enc_pkg SHALL hold the ALU op constants, the opcode/funct constants and the state enum.
REQ-031 The FIFO SHALL be a sub-module named instr_enc_fifo (depth 2, width 64 holding {addr-free instr, reserved}); the address counter SHALL stay in the top level.

Verification
REQ-032 Scenario: start with base_addr=0x400, then item ADD ssel=1 rs1=1 rs2=2 rd=3 with in_last, out_ready=1 -> out_instr=0x00221820 at out_addr=0x400; done pulses after drain.
REQ-033 Scenario: item addi (op=2, ssel=0, rs1=0, rd=8, imm=-1) -> out_instr=0x2008FFFF.
REQ-034 Scenario: out_ready=0 while 3 items are offered -> in_ready drops after 2 pushes; releasing out_ready gives addresses base, base+4, base+8 with no loss or reorder.
REQ-035 Scenario: base_addr=0xFFFFFFFC with 2 items -> addresses 0xFFFFFFFC then 0x00000000.
REQ-036 Scenario (CHECK_EN): ssel=0 op=SUB with in_last -> item dropped, err=1, done pulses, no output.
REQ-037 Scenario: rst asserted mid-stream with 2 entries buffered -> next cycle out_valid=0, busy=0, state IDLE; a following start restarts at the new base_addr.
